// File: rtl/uart_imem_loader.sv
// uart_imem_loader: writes a framed UART program image into instruction memory and holds the core in reset until it loads.
module uart_imem_loader #(
    parameter int         IMEM_DEPTH     = 64,
    parameter int         PROG_VALUE     = 32,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  imem_we,
    output logic [PROG_VALUE-1:0] imem_addr,
    output logic [PROG_VALUE-1:0] imem_wdata,
    output logic                  cpu_rst_n,
    output logic                  load_done,
    output logic                  load_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] DEPTH = 16'(IMEM_DEPTH);

    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR} state_t;

    state_t                state_q;
    logic [15:0]           count_q;
    logic [15:0]           word_idx_q;
    logic [1:0]            byte_idx_q;
    logic [23:0]           asm_q;
    logic [TW-1:0]         idle_q;
    logic                  we_q;
    logic [PROG_VALUE-1:0] addr_q;
    logic [PROG_VALUE-1:0] wdata_q;
    logic                  cpu_rst_n_q;
    logic                  done_q;
    logic                  err_q;

    logic        sync;
    logic        loading;
    logic [15:0] len;

    assign sync    = rx_valid && rx_data == SYNC_BYTE;
    assign loading = state_q == LEN_LO || state_q == LEN_HI || state_q == DATA;
    assign len     = {rx_data, count_q[7:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            asm_q       <= '0;
            idle_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            idle_q <= (rx_valid || !loading) ? '0 : idle_q + 1'b1;
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (sync) begin
                        state_q     <= LEN_LO;
                        done_q      <= 1'b0;
                        err_q       <= 1'b0;
                        cpu_rst_n_q <= 1'b0;
                    end
                end
                LEN_LO: begin
                    if (rx_valid) begin
                        count_q[7:0] <= rx_data;
                        state_q      <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (rx_valid) begin
                        count_q[15:8] <= rx_data;
                        word_idx_q    <= '0;
                        byte_idx_q    <= '0;
                        if (len == 16'd0) begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            cpu_rst_n_q <= 1'b1;
                        end else if (len > DEPTH) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    // little-endian assembly: each byte enters at the top and shifts down
                    if (rx_valid) begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        asm_q      <= {rx_data, asm_q[23:8]};
                        if (byte_idx_q == 2'd3) begin
                            we_q       <= 1'b1;
                            addr_q     <= PROG_VALUE'({word_idx_q, 2'b00});
                            wdata_q    <= PROG_VALUE'({rx_data, asm_q});
                            word_idx_q <= word_idx_q + 16'd1;
                            if (word_idx_q + 16'd1 == count_q) begin
                                state_q     <= DONE;
                                done_q      <= 1'b1;
                                cpu_rst_n_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            // stalled frame: abandon any partial word, keep what was already written
            if (loading && !rx_valid && idle_q == IDLE_LAST) begin
                state_q <= ERR;
                err_q   <= 1'b1;
            end
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_rst_n  = cpu_rst_n_q;
    assign load_done  = done_q;
    assign load_err   = err_q;
endmodule

// File: tb/tb_uart_imem_loader.sv
// tb_uart_imem_loader: scoreboard bench streaming framed images and checking every memory write and status flag.
module tb_uart_imem_loader;
    localparam int DEPTH = 64;
    localparam int TO    = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst_n;
    logic        load_done;
    logic        load_err;

    int          n_checks = 0;
    int          n_fails = 0;
    int          n_wr = 0;
    int          wr0;
    logic [31:0] last_addr = '0;
    logic [63:0] mon_e;
    logic [63:0] exp_q[$];
    logic [7:0]  tx_q[$];

    always #5 clk = ~clk;

    uart_imem_loader #(
        .IMEM_DEPTH(DEPTH),
        .PROG_VALUE(32),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_rst_n(cpu_rst_n),
        .load_done(load_done),
        .load_err(load_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we) begin
            n_wr++;
            last_addr = imem_addr;
            check("addr_in_range", 32'(imem_addr < DEPTH * 4), 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", imem_addr, mon_e[63:32]);
                check("wr_data", imem_wdata, mon_e[31:0]);
            end
        end
    end

    task automatic push(input logic [7:0] b);
        tx_q.push_back(b);
    endtask

    task automatic header(input logic [15:0] cnt);
        push(8'hA5);
        push(cnt[7:0]);
        push(cnt[15:8]);
    endtask

    task automatic push_word(input logic [31:0] w, input int idx);
        for (int i = 0; i < 4; i++) push(w[i*8 +: 8]);
        exp_q.push_back({32'(idx * 4), w});
    endtask

    task automatic send();
        while (tx_q.size() > 0) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = tx_q.pop_front();
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (3) @(negedge clk);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"}, 32'(imem_we), 32'd0);
        check({tag, "_addr"}, imem_addr, 32'd0);
        check({tag, "_wdata"}, imem_wdata, 32'd0);
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
        check({tag, "_done"}, 32'(load_done), 32'd0);
        check({tag, "_err"}, 32'(load_err), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_cpu_rst_n", 32'(cpu_rst_n), 32'd0);

        header(16'd2);
        push_word(32'h00000013, 0);
        push_word(32'h00100093, 1);
        send();
        drain("t1_sb_empty");
        check("t1_done", 32'(load_done), 32'd1);
        check("t1_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        check("t1_err", 32'(load_err), 32'd0);

        wr0 = n_wr;
        push(8'hA5);
        send();
        check("restart_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("restart_done_clr", 32'(load_done), 32'd0);
        push(8'h00);
        push(8'h00);
        send();
        check("t2_done", 32'(load_done), 32'd1);
        check("t2_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        repeat (3) @(negedge clk);
        check("t2_no_writes", 32'(n_wr - wr0), 32'd0);

        wr0 = n_wr;
        header(16'd65);
        send();
        check("t3_err", 32'(load_err), 32'd1);
        check("t3_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("t3_done", 32'(load_done), 32'd0);
        repeat (3) @(negedge clk);
        check("t3_no_writes", 32'(n_wr - wr0), 32'd0);
        header(16'd1);
        push_word(32'hDEADBEEF, 0);
        send();
        drain("t3_sb_empty");
        check("t3_recover_err", 32'(load_err), 32'd0);
        check("t3_recover_done", 32'(load_done), 32'd1);

        wr0 = n_wr;
        header(16'd1);
        push(8'hAA);
        push(8'hBB);
        send();
        repeat (TO - 1) @(negedge clk);
        check("t4_err_not_yet", 32'(load_err), 32'd0);
        @(negedge clk);
        check("t4_err_timeout", 32'(load_err), 32'd1);
        check("t4_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("t4_no_writes", 32'(n_wr - wr0), 32'd0);
        header(16'd1);
        push_word(32'hAABBCCDD, 0);
        send();
        drain("t4_sb_empty");
        check("t4_done", 32'(load_done), 32'd1);
        check("t4_err_clr", 32'(load_err), 32'd0);

        header(16'd1);
        push_word(32'hA5A5A5A5, 0);
        send();
        drain("t5_sb_empty");
        check("t5_done", 32'(load_done), 32'd1);

        header(16'd3);
        push(8'h11);
        push(8'h22);
        send();
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("t6_midreset");
        rst_n = 1'b1;
        @(negedge clk);
        header(16'd3);
        push_word(32'h11223344, 0);
        push_word(32'h55667788, 1);
        push_word(32'h99AABBCC, 2);
        send();
        drain("t6_sb_empty");
        check("t6_done", 32'(load_done), 32'd1);

        header(16'(DEPTH));
        for (int i = 0; i < DEPTH; i++) push_word($urandom, i);
        send();
        drain("t7_sb_empty");
        check("t7_done", 32'(load_done), 32'd1);
        check("t7_last_addr", last_addr, 32'((DEPTH - 1) * 4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
- Writer-side companion to the instruction memory. It receives a program image as a byte stream from the UART receiver and writes it into instruction memory one 32-bit word at a time.
- Each write uses a byte address in the same format the instruction memory read port decodes (word index = addr[31:2]).
- It holds the RISC-V core in reset while loading and releases it on a successful load.
- It sits between the UART RX byte output and the instruction-memory write port.

Parameters:
- IMEM_DEPTH, 64, number of 32-bit words in instruction memory; the upper bound on the word count.
- PROG_VALUE, 32, data and address width.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 100000, maximum idle clocks between bytes once a frame has started.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- rx_valid  input  1  one-cycle strobe; rx_data is a received byte.
- rx_data  input  8  received UART byte.
- imem_we  output  1  one-cycle write strobe to instruction memory.
- imem_addr  output  PROG_VALUE  byte address of the write; bits [1:0] are always 0.
- imem_wdata  output  PROG_VALUE  word to write.
- cpu_rst_n  output  1  core reset; low while idle-after-reset or loading.
- load_done  output  1  high after a successful load until the next frame start.
- load_err  output  1  high after a failed load until the next frame start.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset values:
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_rst_n=0, load_done=0, load_err=0.
  - FSM=IDLE, all counters=0.
- Frame format, in order:
  - SYNC_BYTE.
  - Word count, low byte then high byte (16 bits).
  - count×4 data bytes, each word little-endian (first byte → wdata[7:0]).
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR.
- IDLE:
  - rx_valid with rx_data==SYNC_BYTE → LEN_LO. Clear load_done and load_err, drive cpu_rst_n=0.
  - Any other byte is ignored.
- LEN_LO: on rx_valid, latch count[7:0] → LEN_HI.
- LEN_HI: on rx_valid, latch count[15:8], then evaluate the full count:
  - count==0 → DONE.
  - count>IMEM_DEPTH → ERR.
  - otherwise → DATA, with word index=0 and byte index=0.
- DATA:
  - Each rx_valid shifts the byte into the assembly register at lane byte_idx.
  - On the 4th byte, the next cycle drives imem_we=1 for exactly one cycle, with imem_wdata=assembled word and imem_addr={word_idx,2'b00}.
  - Write latency is 1 clock after the 4th byte's rx_valid.
  - word_idx then increments. When word_idx reaches count, go to DONE in the same cycle as the final write strobe.
- DONE: load_done=1, cpu_rst_n=1. A SYNC_BYTE restarts a load (cpu_rst_n drops to 0 the next cycle).
- ERR:
  - load_err=1, cpu_rst_n=0, no writes.
  - A SYNC_BYTE restarts a load; other bytes are ignored.
- Timeout:
  - In LEN_LO, LEN_HI and DATA, an idle counter increments each cycle without rx_valid and clears on rx_valid.
  - Reaching TIMEOUT_CYCLES → ERR. A partial word is discarded, and words already written stay in memory.
- Boundaries:
  - The SYNC_BYTE value appearing as length or data is treated as data, not a restart.
  - The last permitted word is at address (IMEM_DEPTH-1)*4, and no address beyond it is ever driven.
  - A byte arriving in the same cycle as the write strobe is accepted into the next word, so back-to-back bytes are never dropped.
- Reset mid-load returns to reset values immediately. A partial frame is abandoned and cpu_rst_n stays low.
- rx_valid is assumed at most one cycle wide per byte. Bytes arriving in DONE or ERR, other than SYNC_BYTE, are ignored.

Test Plan:
1. Send A5,02,00,13,00,00,00,93,00,10,00 → two writes: addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093. After that, load_done=1 and cpu_rst_n=1.
2. Send A5,00,00 → no imem_we pulses; load_done=1 and cpu_rst_n=1 within 1 cycle.
3. Send A5,41,00 with IMEM_DEPTH=64 (count 65) → load_err=1, cpu_rst_n=0, zero writes. A following valid frame then succeeds with load_err cleared.
4. Send A5,01,00,AA,BB, then stall for TIMEOUT_CYCLES (test value 50) → load_err=1 with no write. Then send A5,01,00,DD,CC,BB,AA → write 0xAABBCCDD at addr 0.
5. Send A5,01,00,A5,A5,A5,A5 → one write of 0xA5A5A5A5 at addr 0, with no restart.
6. Assert rst_n=0 after 2 data bytes of a 3-word frame → all outputs at reset values next cycle. A new full frame then loads correctly from addr 0.
